// File: rtl/tft_fill_ctrl.sv
// Solid-colour window fill sequencer for the TFT byte transmitter.
// The sequence is CASET + 4 bytes, PASET + 4 bytes, then RAMWR + 3 RGB666 bytes per pixel.
module tft_fill_ctrl #(
  parameter int COORD_W = 9,
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [17:0]        color,
  input  logic               tft_busy,
  output logic               tft_dc,
  output logic [7:0]         tft_data,
  output logic               tft_transmit,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    IDLE, CASET_C, CASET_D, PASET_C, PASET_D, RAMWR_C, PIXEL, FINISH
  } state_t;

  localparam logic [COORD_W:0]   W_LIM = (COORD_W+1)'(WIDTH);
  localparam logic [COORD_W:0]   H_LIM = (COORD_W+1)'(HEIGHT);
  localparam logic [COORD_W-1:0] ONE   = {{(COORD_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [17:0]        color_q, color_d;
  logic [1:0]         sub_q, sub_d;
  logic               tx_q, tx_d, dc_q, dc_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic               can_issue;
  logic               req_bad;
  logic [15:0]        lo_w, hi_w;
  logic [7:0]         coord_byte, pixel_byte;

  // The strobe is registered, so the previous-cycle check also covers tft_busy's one-cycle lag.
  assign can_issue = !tft_busy && !tx_q;
  assign req_bad   = (x1 < x0) || (y1 < y0) || ({1'b0, x1} >= W_LIM) || ({1'b0, y1} >= H_LIM);

  always_comb begin
    lo_w = (state_q == PASET_D) ? 16'(y0_q) : 16'(x0_q);
    hi_w = (state_q == PASET_D) ? 16'(y1_q) : 16'(x1_q);
    case (sub_q)
      2'd0:    coord_byte = lo_w[15:8];
      2'd1:    coord_byte = lo_w[7:0];
      2'd2:    coord_byte = hi_w[15:8];
      default: coord_byte = hi_w[7:0];
    endcase
    case (sub_q)
      2'd0:    pixel_byte = {color_q[17:12], 2'b00};
      2'd1:    pixel_byte = {color_q[11:6], 2'b00};
      default: pixel_byte = {color_q[5:0], 2'b00};
    endcase
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    sub_d   = sub_q;
    tx_d    = 1'b0;
    dc_d    = dc_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_done && start) begin
          x0_d    = x0;
          x1_d    = x1;
          y0_d    = y0;
          y1_d    = y1;
          color_d = color;
          if (req_bad) begin
            error_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            col_d   = x0;
            row_d   = y0;
            sub_d   = '0;
            state_d = CASET_C;
          end
        end
      end
      CASET_C, PASET_C, RAMWR_C: begin
        if (can_issue) begin
          tx_d   = 1'b1;
          dc_d   = 1'b0;
          sub_d  = '0;
          if (state_q == CASET_C) begin
            data_d  = 8'h2A;
            state_d = CASET_D;
          end else if (state_q == PASET_C) begin
            data_d  = 8'h2B;
            state_d = PASET_D;
          end else begin
            data_d  = 8'h2C;
            state_d = PIXEL;
          end
        end
      end
      CASET_D, PASET_D: begin
        if (can_issue) begin
          tx_d   = 1'b1;
          dc_d   = 1'b1;
          data_d = coord_byte;
          sub_d  = sub_q + 2'd1;
          if (sub_q == 2'd3) begin
            sub_d   = '0;
            state_d = (state_q == CASET_D) ? PASET_C : RAMWR_C;
          end
        end
      end
      PIXEL: begin
        if (can_issue) begin
          tx_d   = 1'b1;
          dc_d   = 1'b1;
          data_d = pixel_byte;
          sub_d  = sub_q + 2'd1;
          if (sub_q == 2'd2) begin
            sub_d = '0;
            if (col_q == x1_q) begin
              col_d = x0_q;
              if (row_q == y1_q) state_d = FINISH;
              else               row_d   = row_q + ONE;
            end else begin
              col_d = col_q + ONE;
            end
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      sub_q   <= '0;
      tx_q    <= 1'b0;
      dc_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
      sub_q   <= sub_d;
      tx_q    <= tx_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign tft_transmit = tx_q;
  assign tft_dc       = dc_q;
  assign tft_data     = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
